fetch_queue: RTL and testbench

Instruction-fetch front end that is the transmitting side of the decode interface: it generates sequential PCs, reads instruction memory with a fixed one-cycle latency, buffers fetched words in a small FIFO, and presents them to the decode stage as instruction words, PC and PC+4 under a valid/stall handshake. Redirects from Execute (taken branch, JAL, JALR) flush the buffer and any in-flight read and restart fetch at the target.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_queue.sv | 85 ++++++++
 tb/tb_fetch_queue.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with a separate occupancy count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  fetch_entry_t           din,
  output fetch_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Flush shares the reset path so a redirect empties the buffer in one edge.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: sequential PC generation, one-cycle imem read, buffered
// hand-off to decode with valid/stall, and redirect flush from Execute.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemRdata,
  input  logic        RedirectE,
  input  logic [31:0] RedirectPCE,
  input  logic        StallD,
  output logic        ValidD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [31:0]  fetch_pc_p0;
  logic [31:0]  req_pc_p1;
  logic         vld_p1;
  logic         kill_p1;
  logic         issue;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  logic [AW:0]  count;
  fetch_entry_t din;
  fetch_entry_t head;

  // In-flight reads reserve a slot so a response can never meet a full FIFO.
  assign issue = ~reset & ~RedirectE & ((count + {{AW{1'b0}}, vld_p1}) < DEPTH_C);

  // Stage p0: request issue and PC sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_p0 <= RESET_PC;
      vld_p1      <= 1'b0;
      kill_p1     <= 1'b0;
    end else begin
      vld_p1  <= issue;
      kill_p1 <= RedirectE & (issue | vld_p1);
      if (RedirectE)  fetch_pc_p0 <= RedirectPCE & ~32'h3;
      else if (issue) fetch_pc_p0 <= fetch_pc_p0 + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) req_pc_p1 <= fetch_pc_p0;
  end

  // Stage p1: response capture into the buffer
  assign push = vld_p1 & ~kill_p1 & ~RedirectE & ~full;
  assign pop  = ~empty & ~StallD & ~RedirectE;
  assign din  = '{pc: req_pc_p1, instr: ImemRdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (RedirectE),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign ImemReq  = issue;
  assign ImemAddr = fetch_pc_p0;
  assign ValidD   = ~empty;
  assign InstrD   = empty ? NOP_INSTR : head.instr;
  assign PCD      = empty ? 32'd0 : head.pc;
  assign PCPlus4D = PCD + 32'd4;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: expected decode stream and request stream
// come from a sequential-PC reference model that restarts on redirect/reset.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic [31:0] ImemRdata = 32'd0;
  logic        RedirectE = 1'b0;
  logic [31:0] RedirectPCE = 32'd0;
  logic        StallD = 1'b0;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;

  int errors = 0;
  int checks = 0;

  fetch_entry_t exp_q[$];
  logic [31:0]  gen_pc;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .ImemReq     (ImemReq),
    .ImemAddr    (ImemAddr),
    .ImemRdata   (ImemRdata),
    .RedirectE   (RedirectE),
    .RedirectPCE (RedirectPCE),
    .StallD      (StallD),
    .ValidD      (ValidD),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D)
  );

  always #5 clk = ~clk;

  // Memory word i holds the value i.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{pc: gen_pc, instr: mem_word(gen_pc)});
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] a);
    exp_q.delete();
    gen_pc = a & ~32'h3;
    topup();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    topup();
  endtask

  // Instruction memory: fixed one-cycle read latency, garbage when idle.
  logic        pend_req;
  logic [31:0] pend_addr;
  initial forever begin
    @(negedge clk);
    pend_req  = ImemReq;
    pend_addr = ImemAddr;
    @(posedge clk);
    #1;
    ImemRdata = pend_req ? mem_word(pend_addr) : $urandom;
  end

  // Monitor: request-credit model plus in-order decode stream comparison.
  int          occ = 0;
  logic [31:0] nreq = RESET_PC;
  initial forever begin
    logic         exp_req;
    logic         take;
    fetch_entry_t e;
    @(negedge clk);
    if (reset) begin
      chk("req_in_reset", 32'(ImemReq), 32'd0);
      occ  = 0;
      nreq = RESET_PC;
    end else begin
      exp_req = !RedirectE && (occ < DEPTH);
      chk("imem_req", 32'(ImemReq), 32'(exp_req));
      if (ImemReq) begin
        chk("imem_addr", ImemAddr, nreq);
        nreq = nreq + 32'd4;
      end
      take = ValidD && !StallD && !RedirectE;
      if (!ValidD) begin
        chk("idle_instr", InstrD, NOP_INSTR);
        chk("idle_pc", PCD, 32'd0);
        chk("idle_pc4", PCPlus4D, 32'd4);
      end
      if (take) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_empty: got pc %h expected no transfer", PCD);
        end else begin
          e = exp_q.pop_front();
          chk("stream_pc", PCD, e.pc);
          chk("stream_instr", InstrD, e.instr);
          chk("stream_pc4", PCPlus4D, e.pc + 32'd4);
        end
      end
      if (RedirectE) begin
        occ  = 0;
        nreq = RedirectPCE & ~32'h3;
      end else begin
        occ = occ + (exp_req ? 1 : 0) - (take ? 1 : 0);
      end
    end
  end

  task automatic redir_check(input logic [31:0] tgt);
    RedirectE   = 1'b1;
    RedirectPCE = tgt;
    StallD      = 1'b0;
    restart(tgt);
    #1;
    chk("req_redirect", 32'(ImemReq), 32'd0);
    tick();
    RedirectE = 1'b0;
    #1;
    chk("req_r1", 32'(ImemReq), 32'd1);
    chk("addr_r1", ImemAddr, tgt & ~32'h3);
    chk("valid_r1", 32'(ValidD), 32'd0);
    tick();
    chk("valid_r2", 32'(ValidD), 32'd0);
    tick();
    chk("valid_r3", 32'(ValidD), 32'd1);
    chk("pcd_r3", PCD, tgt & ~32'h3);
  endtask

  logic [31:0] targets [4];

  initial begin
    targets[0] = 32'h0000_0100;
    targets[1] = 32'h0000_0203;
    targets[2] = 32'hFFFF_FFF4;
    targets[3] = 32'h0000_1000;

    // Reset state
    repeat (3) tick();
    chk("rst_req", 32'(ImemReq), 32'd0);
    chk("rst_addr", ImemAddr, RESET_PC);
    chk("rst_valid", 32'(ValidD), 32'd0);
    chk("rst_instr", InstrD, NOP_INSTR);
    chk("rst_pcd", PCD, 32'd0);
    chk("rst_pc4", PCPlus4D, 32'd4);

    // First fetches after release
    reset = 1'b0;
    restart(RESET_PC);
    #1;
    chk("first_req", 32'(ImemReq), 32'd1);
    chk("first_addr", ImemAddr, 32'd0);
    tick();
    chk("addr_c1", ImemAddr, 32'd4);
    chk("valid_c1", 32'(ValidD), 32'd0);
    tick();
    chk("addr_c2", ImemAddr, 32'd8);
    chk("valid_c2", 32'(ValidD), 32'd1);
    chk("pcd_c2", PCD, 32'd0);
    chk("instr_c2", InstrD, 32'd0);
    tick();
    chk("pcd_c3", PCD, 32'd4);
    chk("instr_c3", InstrD, 32'd1);
    chk("pc4_c3", PCPlus4D, 32'd8);

    // Decode stalled: buffer fills and requests stop
    StallD = 1'b1;
    repeat (10) tick();
    chk("stall_req", 32'(ImemReq), 32'd0);
    chk("stall_valid", 32'(ValidD), 32'd1);
    StallD = 1'b0;
    #1;
    chk("unstall_req_same", 32'(ImemReq), 32'd0);
    tick();
    chk("unstall_req_next", 32'(ImemReq), 32'd1);
    repeat (6) tick();

    // Redirect while full
    StallD = 1'b1;
    repeat (8) tick();
    chk("full_valid", 32'(ValidD), 32'd1);
    redir_check(32'h0000_0100);
    repeat (3) tick();

    // Redirect with a read in flight, unaligned target
    redir_check(32'h0000_0203);
    repeat (3) tick();

    // Address wrap at the top of memory
    redir_check(32'hFFFF_FFF8);
    chk("addr_wrap", ImemAddr, 32'd0);
    tick();
    chk("pcd_wrap", PCD, 32'hFFFF_FFFC);
    chk("pc4_wrap", PCPlus4D, 32'd0);
    tick();
    chk("pcd_after_wrap", PCD, 32'd0);
    repeat (4) tick();

    // Randomized stall and redirect traffic
    for (int i = 0; i < 600; i++) begin
      StallD = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 19) == 0) begin
        RedirectE   = 1'b1;
        RedirectPCE = ($urandom_range(0, 1) == 0) ? targets[$urandom_range(0, 3)] : $urandom;
        restart(RedirectPCE);
      end else begin
        RedirectE = 1'b0;
      end
      tick();
    end
    RedirectE = 1'b0;
    StallD    = 1'b0;
    repeat (4) tick();

    // Reset mid-stream with three entries buffered
    RedirectE   = 1'b1;
    RedirectPCE = 32'h0000_0040;
    StallD      = 1'b1;
    restart(32'h0000_0040);
    tick();
    RedirectE = 1'b0;
    repeat (4) tick();
    chk("pre_rst_valid", 32'(ValidD), 32'd1);
    chk("pre_rst_pcd", PCD, 32'h0000_0040);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(ValidD), 32'd0);
    chk("mid_rst_instr", InstrD, NOP_INSTR);
    chk("mid_rst_pcd", PCD, 32'd0);
    reset  = 1'b0;
    StallD = 1'b0;
    restart(RESET_PC);
    #1;
    chk("rerun_req", 32'(ImemReq), 32'd1);
    chk("rerun_addr", ImemAddr, RESET_PC);
    repeat (3) tick();
    chk("rerun_valid", 32'(ValidD), 32'd1);
    chk("rerun_pcd", PCD, RESET_PC + 32'd4);
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
